dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares the single-port data memory (combinational read, write on posedge clk) between NREQ requesters.
//  Example requesters: port 0 = CPU load/store unit, port 1 = program/data loader.
//  Arbitration is round-robin. Each accepted request is latched and drives the memory interface for one cycle.
//  The read data or write acknowledge returns on a registered per-port response.
// PARAMETERS
//  NREQ   2    number of requesters (2..8)
//  DEPTH  500  memory depth in words; address is a word index
//  AW     32   address width
//  DW     32   data width
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  rst        in   1           asynchronous reset, active-high
//  req        in   NREQ        per-port request; held until gnt
//  req_we     in   NREQ        1 = write, 0 = read
//  req_addr   in   NREQ x AW   per-port word address
//  req_wdata  in   NREQ x DW   per-port write data
//  gnt        out  NREQ        one-hot accept pulse; request is consumed this cycle
//  rsp_valid  out  NREQ        one-hot, 1-cycle response strobe
//  rsp_rdata  out  DW          read data, shared; valid with rsp_valid
//  rsp_err    out  1           address error, valid with rsp_valid
//  busy       out  1           transaction in flight (state != IDLE)
//  mem_read   out  1           drives memory read enable
//  mem_write  out  1           drives memory write enable
//  mem_addr   out  AW          drives memory address
//  mem_wdata  out  DW          drives memory write data
//  mem_rdata  in   DW          memory read data (combinational)
// BEHAVIOUR
//  Reset (async):
//   - All outputs, command registers and rsp_rdata go to 0; state = IDLE.
//   - RR pointer is reset so port 0 has top priority.
//   - A transaction in flight is dropped: no response, no write.
//  States:
//   - IDLE: if any req, grant winner (gnt comb., same cycle), latch we/addr/wdata/port, go ACCESS. Else stay.
//   - ACCESS: drive mem_* from latched regs for exactly one cycle.
//     - Write: mem_write = 1, mem_read = 0. Memory writes at the closing edge.
//     - Read: mem_read = 1, mem_rdata captured into rsp_rdata at the closing edge.
//     - Go RESP.
//   - RESP: rsp_valid[port] = 1 and rsp_err are registered outputs.
//     - rsp_rdata holds read data; for writes it is 0.
//     - Arbitration is live here exactly as in IDLE: a new grant in RESP goes to ACCESS, otherwise to IDLE.
//  Timing:
//   - Latency: gnt at cycle N, memory access at N+1, rsp_valid at N+2.
//   - Peak throughput: 1 transaction per 2 cycles (grant overlaps RESP).
//  Outputs outside ACCESS:
//   - mem_read = mem_write = 0; mem_addr and mem_wdata hold their last value.
//  Round-robin:
//   - Search starts at (last_granted + 1) mod NREQ.
//   - The pointer updates only on a grant.
//   - Simultaneous requests: the port nearest after the last winner wins; a loser keeps req high and wins next.
//  gnt is never asserted in ACCESS. A request that drops before gnt is simply not served.
//  Addresses are passed unmodified. Width truncation to $clog2(DEPTH) is the memory's concern.
// CONFIGURATION
//  DM_ARB_ADDR_CHECK_EN defined:
//   - A request with addr >= DEPTH is granted normally.
//   - In ACCESS: mem_read = mem_write = 0 (no memory access).
//   - In RESP: rsp_err = 1, rsp_rdata = 0.
//  DM_ARB_ADDR_CHECK_EN undefined:
//   - No check; all addresses reach memory.
//   - rsp_err tied 0.
//   - The port list is identical either way.
// STRUCTURE
//  Package dm_arb_pkg:
//   - state_t enum {IDLE, ACCESS, RESP}
//   - dm_cmd_t struct {we, addr, wdata, port}
//   - constants DM_DEPTH = 500 and DM_NREQ = 2
//  Sub-module rr_arbiter:
//   - Inputs: req[NREQ], advance, clk, rst.
//   - Outputs: one-hot gnt[NREQ] and the granted index.
//   - Owns the last_granted pointer.
//  The top level holds the FSM, the command register and the response registers.
// TESTING
//  1. Port 0 writes 0xDEADBEEF @5, then reads @5 -> mem_write for 1 cycle at N+1; read rsp at N+2 with rdata 0xDEADBEEF.
//  2. Both ports req at the same cycle after reset -> gnt order 0,1,0,1 with persistent reqs; each gnt exactly 2 cycles apart.
//  3. Back-to-back reads from port 1 @0..3 -> rsp_valid every 2nd cycle, rdata matching preloaded 0x10..0x13.
//  4. rst asserted in ACCESS of a write 0x1234 @7 -> outputs 0 at once, no rsp; memory @7 reads 0.
//  5. Read @499 then @500 -> first: rsp_err = 0. Second: rsp_err = 1, rsp_rdata = 0 and no mem_read
//     with DM_ARB_ADDR_CHECK_EN defined; rsp_err = 0 with it undefined.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  localparam int DM_DEPTH = 500;
  localparam int DM_NREQ  = 2;
  localparam int DM_AW    = 32;
  localparam int DM_DW    = 32;
  localparam int DM_PW    = 3;  // port index field, wide enough for 8 requesters

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // The command register bounds AW and DW to 32 bits.
  typedef struct packed {
    logic             we;
    logic [DM_AW-1:0] addr;
    logic [DM_DW-1:0] wdata;
    logic [DM_PW-1:0] port;
  } dm_cmd_t;

  function automatic logic [7:0] port_onehot(input logic [DM_PW-1:0] port);
    return 8'b1 << port;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr.sv
// Round-robin arbiter: one-hot grant plus index; search starts after the last winner.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest requester overwrites.
  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  // Resetting to the highest index gives port 0 top priority after reset.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 last <= IW'(NREQ - 1);
    else if (advance && |req) last <= idx;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between NREQ requesters.
// Define DM_ARB_ADDR_CHECK_EN to block out-of-range accesses and flag them with rsp_err.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NREQ  = DM_NREQ,
  parameter int DEPTH = DM_DEPTH,
  parameter int AW    = DM_AW,
  parameter int DW    = DM_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0][AW-1:0] req_addr,
  input  logic [NREQ-1:0][DW-1:0] req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef DM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  state_t          state;
  dm_cmd_t         cmd;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            can_grant;
  logic            sel_bad;
  logic            cmd_bad;

  // No grant while the memory is busy with a latched command, nor while reset holds everything low.
  assign can_grant = !rst && (state != ACCESS);
  assign gnt       = can_grant ? arb_gnt : '0;
  assign busy      = (state != IDLE);
  assign mem_addr  = AW'(cmd.addr);
  assign mem_wdata = DW'(cmd.wdata);
  assign sel_bad   = ADDR_CHECK && (req_addr[arb_idx] >= AW'(DEPTH));
  assign cmd_bad   = ADDR_CHECK && (cmd.addr >= DM_AW'(DEPTH));

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (can_grant),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        ACCESS: begin
          state     <= RESP;
          rsp_valid <= NREQ'(port_onehot(cmd.port));
          rsp_err   <= cmd_bad;
          rsp_rdata <= (cmd.we || cmd_bad) ? '0 : mem_rdata;
        end
        // IDLE and RESP arbitrate identically; a grant in RESP overlaps the response.
        default: begin
          if (|arb_gnt) begin
            state     <= ACCESS;
            cmd       <= '{we:    req_we[arb_idx],
                           addr:  DM_AW'(req_addr[arb_idx]),
                           wdata: DM_DW'(req_wdata[arb_idx]),
                           port:  DM_PW'(arb_idx)};
            mem_read  <= !req_we[arb_idx] && !sel_bad;
            mem_write <=  req_we[arb_idx] && !sel_bad;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic, checked by a transaction-level model and scoreboard.
module tb_dm_arbiter;

  localparam int NREQ  = 2;
  localparam int DEPTH = 500;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ-1:0][31:0]  req_addr;
  logic [NREQ-1:0][31:0]  req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic                   busy;
  logic                   mem_read;
  logic                   mem_write;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;

  dm_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory seen by the DUT: 512 words, because the memory keeps only the low 9 address bits.
  logic [31:0] tb_mem  [512];
  logic [31:0] ref_mem [512];
  assign mem_rdata = tb_mem[mem_addr[8:0]];

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DM_ARB_ADDR_CHECK_EN
    return a >= 32'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          bad;
    int          due;
  } exp_t;

  exp_t sb[$];

  initial begin
    for (int i = 0; i < 512; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      tb_mem[i]  = 32'h10 + 32'(i);
      ref_mem[i] = 32'h10 + 32'(i);
    end
    tb_mem[499] = 32'hAA;  ref_mem[499] = 32'hAA;
    tb_mem[500] = 32'h55;  ref_mem[500] = 32'h55;
    forever begin
      @(posedge clk);
      if (mem_write) tb_mem[mem_addr[8:0]] <= mem_wdata;
    end
  end

  // Transaction model: a grant is possible in any cycle not directly after a grant;
  // the winner is the requester at the smallest rotational distance past the last winner.
  initial begin
    int   last;
    bit   g1, g2;
    exp_t acc, e;
    int   win, best, d;
    last = NREQ - 1;
    g1 = 1'b0;
    g2 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = NREQ - 1;
        g1 = 1'b0;
        g2 = 1'b0;
        sb.delete();
        check("gnt_in_reset", 64'(gnt), 64'(0));
        check("busy_in_reset", 64'(busy), 64'(0));
      end else begin
        win  = -1;
        best = NREQ;
        if (!g1) begin
          for (int p = 0; p < NREQ; p++) begin
            d = (p - last - 1 + NREQ) % NREQ;
            if (req[p] && d < best) begin
              best = d;
              win  = p;
            end
          end
        end
        check("gnt", 64'(gnt), (win >= 0) ? 64'(1) << win : 64'(0));
        check("busy", 64'(busy), 64'(g1 || g2));
        if (g1) begin
          check("mem_read",  64'(mem_read),  64'(!acc.we && !acc.bad));
          check("mem_write", 64'(mem_write), 64'(acc.we && !acc.bad));
          check("mem_addr",  64'(mem_addr),  64'(acc.addr));
          if (acc.we) check("mem_wdata", 64'(mem_wdata), 64'(acc.wdata));
        end else begin
          check("mem_read_idle",  64'(mem_read),  64'(0));
          check("mem_write_idle", 64'(mem_write), 64'(0));
        end
        if (win >= 0) begin
          e = '{port: win, we: req_we[win], addr: req_addr[win], wdata: req_wdata[win],
                bad: addr_bad(req_addr[win]), due: cyc + 2};
          sb.push_back(e);
          acc  = e;
          last = win;
        end
        g2 = g1;
        g1 = (win >= 0);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    exp_t        e;
    logic [31:0] exp_rdata;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          check("rsp_late", 64'(cyc), 64'(e.due));
        end
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'(0));
          end else begin
            e = sb.pop_front();
            exp_rdata = (e.we || e.bad) ? 32'h0 : ref_mem[e.addr[8:0]];
            check("rsp_valid", 64'(rsp_valid), 64'(1) << e.port);
            check("rsp_cycle", 64'(cyc), 64'(e.due));
            check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            check("rsp_err",   64'(rsp_err),   64'(e.bad));
            if (e.we && !e.bad) ref_mem[e.addr[8:0]] = e.wdata;
          end
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},       64'(gnt),       64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
    check({tag, "_rsp_err"},   64'(rsp_err),   64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_mem_read"},  64'(mem_read),  64'(0));
    check({tag, "_mem_write"}, 64'(mem_write), 64'(0));
    check({tag, "_mem_addr"},  64'(mem_addr),  64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  // Leaves the caller one step after a rising edge, where inputs are driven.
  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    req[p]       = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = a;
    req_wdata[p] = d;
  endtask

  task automatic wait_gnt(input int p);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = gnt[p];
      @(posedge clk);
      #1;
    end
    req[p] = 1'b0;
    if (!got) check("gnt_timeout", 64'(0), 64'(1));
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    set_req(p, we, a, d);
    wait_gnt(p);
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cmd(input int p);
    req_we[p]    = ($urandom_range(0, 1) == 1);
    req_addr[p]  = ($urandom_range(0, 7) == 0) ? 32'(496 + $urandom_range(0, 23))
                                               : 32'($urandom_range(0, 63));
    req_wdata[p] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int              order[$];
    logic [NREQ-1:0] gs;
    logic            was;

    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    reset_dut();

    // Write then read back the same word.
    issue(0, 1'b1, 32'd5, 32'hDEADBEEF);
    issue(0, 1'b0, 32'd5, 32'h0);
    drain();

    // Two persistent requesters from reset alternate 0,1,0,1.
    reset_dut();
    set_req(0, 1'b0, 32'd0, 32'h0);
    set_req(1, 1'b0, 32'd1, 32'h0);
    for (int n = 0; n < 16 && order.size() < 4; n++) begin
      @(negedge clk);
      gs = gnt;
      if (gs != '0) order.push_back(gs[1] ? 1 : 0);
      @(posedge clk);
      #1;
    end
    req = '0;
    check("rr_grant_count", 64'(order.size()), 64'(4));
    for (int i = 0; i < order.size(); i++) check("rr_order", 64'(order[i]), 64'(i % 2));
    drain();

    // Back-to-back reads from port 1 over the preloaded words.
    for (int k = 0; k < 4; k++) issue(1, 1'b0, 32'(k), 32'h0);
    drain();

    // Reset during the access cycle of a write drops it.
    reset_dut();
    issue(0, 1'b1, 32'd7, 32'h1234);
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("reset_in_access");
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("mem7_not_written", 64'(tb_mem[7]), 64'(0));
    issue(0, 1'b0, 32'd7, 32'h0);
    drain();

    // Last valid word, then first out-of-range word.
    issue(1, 1'b0, 32'd499, 32'h0);
    issue(1, 1'b0, 32'd500, 32'h0);
    drain();

    // Random traffic on both ports.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      gs = gnt;
      @(posedge clk);
      #1;
      for (int p = 0; p < NREQ; p++) begin
        was = req[p];
        if (gs[p] || !was) begin
          req[p] = gs[p] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
          if (req[p]) rand_cmd(p);
        end
      end
    end
    req = '0;
    drain();

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
